// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths and types for the writeback arbiter
package regfile_write_arbiter_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 3;
    localparam int NUM_REGS    = 1 << ADDR_W;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_holding_slot.sv
// rtl/regfile_write_arbiter_wb_holding_slot.sv - one-entry writeback holding register
module wb_holding_slot #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_dest_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              grant_i,
    output logic              load_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] dest_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A granted occupant leaves at the same edge a new one may arrive.
    assign in_ready_o = !valid_q || grant_i;
    assign load_o     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q && !grant_i;
        dest_d  = dest_q;
        data_d  = data_q;
        if (load_o) begin
            valid_d = 1'b1;
            dest_d  = in_dest_i;
            data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign dest_o  = dest_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source round-robin arbiter for the register file write port
module regfile_write_arbiter #(
    parameter int DATA_W      = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W      = regfile_write_arbiter_pkg::ADDR_W,
    parameter int STALL_CNT_W = regfile_write_arbiter_pkg::STALL_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_dest,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_dest,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    input  logic [ADDR_W-1:0]        rd_addr_1,
    input  logic [ADDR_W-1:0]        rd_addr_2,
    output logic                     hazard_1,
    output logic                     hazard_2,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic [STALL_CNT_W-1:0]   contention_cnt
);
    import regfile_write_arbiter_pkg::*;

    localparam int N_REGS = 1 << ADDR_W;

    logic              a_load, b_load, a_vld, b_vld, grant_a, grant_b;
    logic [ADDR_W-1:0] a_dst, b_dst;
    logic [DATA_W-1:0] a_dat, b_dat;

    port_t                  rr_q, rr_d, older_q, older_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   both, same_dest;

    wb_holding_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk(clk), .rst(rst),
        .in_valid_i(a_valid), .in_ready_o(a_ready),
        .in_dest_i(a_dest), .in_data_i(a_data),
        .grant_i(grant_a), .load_o(a_load),
        .valid_o(a_vld), .dest_o(a_dst), .data_o(a_dat)
    );

    wb_holding_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clk(clk), .rst(rst),
        .in_valid_i(b_valid), .in_ready_o(b_ready),
        .in_dest_i(b_dest), .in_data_i(b_data),
        .grant_i(grant_b), .load_o(b_load),
        .valid_o(b_vld), .dest_o(b_dst), .data_o(b_dat)
    );

    assign both      = a_vld && b_vld;
    assign same_dest = (a_dst == b_dst);

    // Same destination must drain in arrival order; otherwise alternate fairly.
    always_comb begin
        grant_a = 1'b0;
        if (a_vld) begin
            if (!b_vld)
                grant_a = 1'b1;
            else if (same_dest)
                grant_a = (older_q == PORT_A);
            else
                grant_a = (rr_q == PORT_A);
        end
        grant_b = b_vld && !grant_a;
    end

    always_comb begin
        rr_d = rr_q;
        if (both && !same_dest)
            rr_d = grant_a ? PORT_B : PORT_A;

        older_d = older_q;
        if (a_load && b_load)
            older_d = PORT_A;
        else if (a_load)
            older_d = PORT_B;
        else if (b_load)
            older_d = PORT_A;

        cnt_d = cnt_q;
        if (both && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= PORT_A;
            older_q <= PORT_A;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            older_q <= older_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        reg_write_dest = '0;
        reg_write_data = '0;
        if (grant_a) begin
            reg_write_dest = a_dst;
            reg_write_data = a_dat;
        end else if (grant_b) begin
            reg_write_dest = b_dst;
            reg_write_data = b_dat;
        end
        reg_write_en = (grant_a || grant_b) && (reg_write_dest != '0);
    end

    // Register 0 is hardwired, so it never needs to stall decode.
    always_comb begin
        pending = '0;
        for (int d = 1; d < N_REGS; d++)
            pending[d] = (a_vld && a_dst == ADDR_W'(d)) || (b_vld && b_dst == ADDR_W'(d));
    end

    assign hazard_1       = pending[rd_addr_1];
    assign hazard_2       = pending[rd_addr_2];
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [2:0]  a_dest, b_dest, rd_addr_1, rd_addr_2, reg_write_dest;
    logic [15:0] a_data, b_data, reg_write_data, contention_cnt;
    logic        reg_write_en, hazard_1, hazard_2;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2),
        .pending(pending), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 0; b_valid = 0; a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
        rd_addr_1 = 0; rd_addr_2 = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== 20'h0) begin
            errors++; $display("FAIL reset_write en=%b dest=%0d data=%h want 0", reg_write_en, reg_write_dest, reg_write_data);
        end
        checks++;
        if ({a_ready, b_ready, hazard_1, hazard_2, pending, contention_cnt} !== {4'b1100, 8'h00, 16'h0000}) begin
            errors++; $display("FAIL reset_state ar=%b br=%b h=%b%b pend=%h cnt=%0d want ready=11 rest 0",
                               a_ready, b_ready, hazard_1, hazard_2, pending, contention_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        a_valid = 1; a_dest = 3; a_data = 16'h1234;
        tick();
        a_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data, pending} !== {1'b1, 3'd3, 16'h1234, 8'h08}) begin
            errors++; $display("FAIL single_write en=%b dest=%0d data=%h pend=%h want 1/3/1234/08",
                               reg_write_en, reg_write_dest, reg_write_data, pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_en, pending, reg_write_dest, reg_write_data} !== 28'h0) begin
            errors++; $display("FAIL single_idle en=%b pend=%h dest=%0d data=%h want all 0",
                               reg_write_en, pending, reg_write_dest, reg_write_data);
        end
    endtask

    task automatic test_different_dests;
        a_valid = 1; a_dest = 1; a_data = 16'h0011;
        b_valid = 1; b_dest = 2; b_data = 16'h0022;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data, pending, b_ready} !== {1'b1, 3'd1, 16'h0011, 8'h06, 1'b0}) begin
            errors++; $display("FAIL diff_first en=%b dest=%0d data=%h pend=%h br=%b want 1/1/0011/06/0",
                               reg_write_en, reg_write_dest, reg_write_data, pending, b_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd2, 16'h0022}) begin
            errors++; $display("FAIL diff_second en=%b dest=%0d data=%h want 1/2/0022",
                               reg_write_en, reg_write_dest, reg_write_data);
        end
        a_valid = 1; b_valid = 1;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_dest, reg_write_data} !== {3'd2, 16'h0022}) begin
            errors++; $display("FAIL diff_repeat_first dest=%0d data=%h want 2/0022", reg_write_dest, reg_write_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data, contention_cnt} !== {1'b1, 3'd1, 16'h0011, 16'd2}) begin
            errors++; $display("FAIL diff_repeat_second en=%b dest=%0d data=%h cnt=%0d want 1/1/0011/2",
                               reg_write_en, reg_write_dest, reg_write_data, contention_cnt);
        end
        tick();
    endtask

    task automatic test_same_dest_ordering;
        b_valid = 1; b_dest = 5; b_data = 16'hBBBB;
        tick();
        b_valid = 0;
        a_valid = 1; a_dest = 5; a_data = 16'hAAAA;
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd5, 16'hBBBB}) begin
            errors++; $display("FAIL order_first en=%b dest=%0d data=%h want 1/5/BBBB", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        a_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd5, 16'hAAAA}) begin
            errors++; $display("FAIL order_second en=%b dest=%0d data=%h want 1/5/AAAA", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
    endtask

    task automatic test_same_edge_same_dest;
        // Contested pair leaves rr pointing at B.
        a_valid = 1; a_dest = 1; a_data = 16'h0101;
        b_valid = 1; b_dest = 2; b_data = 16'h0202;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        a_valid = 1; a_dest = 6; a_data = 16'h6A6A;
        b_valid = 1; b_dest = 6; b_data = 16'h6B6B;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_dest, reg_write_data} !== {3'd6, 16'h6A6A}) begin
            errors++; $display("FAIL older_first dest=%0d data=%h want 6/6A6A", reg_write_dest, reg_write_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_dest, reg_write_data} !== {3'd6, 16'h6B6B}) begin
            errors++; $display("FAIL older_second dest=%0d data=%h want 6/6B6B", reg_write_dest, reg_write_data);
        end
        a_valid = 1; a_dest = 1; a_data = 16'h0101;
        b_valid = 1; b_dest = 2; b_data = 16'h0202;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_dest, reg_write_data} !== {3'd2, 16'h0202}) begin
            errors++; $display("FAIL rr_kept dest=%0d data=%h want 2/0202", reg_write_dest, reg_write_data);
        end
        tick();
        tick();
    endtask

    task automatic test_dest_zero;
        a_valid = 1; a_dest = 0; a_data = 16'hFFFF;
        tick();
        a_valid = 0;
        @(negedge clk);
        checks++;
        if ({reg_write_en, a_ready, pending} !== {1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL dest0_grant en=%b ar=%b pend=%h want 0/1/00", reg_write_en, a_ready, pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({reg_write_en, a_ready, reg_write_data} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL dest0_after en=%b ar=%b data=%h want 0/1/0000", reg_write_en, a_ready, reg_write_data);
        end
    endtask

    task automatic test_hazard;
        b_valid = 1; b_dest = 4; b_data = 16'h4444;
        rd_addr_1 = 4; rd_addr_2 = 0;
        tick();
        b_valid = 0;
        @(negedge clk);
        checks++;
        if ({hazard_1, hazard_2, pending} !== {1'b1, 1'b0, 8'h10}) begin
            errors++; $display("FAIL hazard_set h1=%b h2=%b pend=%h want 1/0/10", hazard_1, hazard_2, pending);
        end
        rd_addr_2 = 4;
        #1;
        checks++;
        if (hazard_2 !== 1'b1) begin
            errors++; $display("FAIL hazard_2 h2=%b want 1", hazard_2);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({hazard_1, hazard_2} !== 2'b00) begin
            errors++; $display("FAIL hazard_clear h1=%b h2=%b want 0/0", hazard_1, hazard_2);
        end
        rd_addr_1 = 0; rd_addr_2 = 0;
    endtask

    task automatic test_reset_mid_flight;
        a_valid = 1; a_dest = 1; a_data = 16'h1111;
        b_valid = 1; b_dest = 2; b_data = 16'h2222;
        tick();
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if ({pending, contention_cnt} !== {8'h06, 16'd5}) begin
            errors++; $display("FAIL pre_reset pend=%h cnt=%0d want 06/5", pending, contention_cnt);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({reg_write_en, pending, contention_cnt, a_ready, b_ready} !== {1'b0, 8'h00, 16'd0, 2'b11}) begin
            errors++; $display("FAIL async_reset en=%b pend=%h cnt=%0d ar=%b br=%b want 0/00/0/1/1",
                               reg_write_en, pending, contention_cnt, a_ready, b_ready);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({reg_write_en, pending} !== 9'h0) begin
                errors++; $display("FAIL post_reset_%0d en=%b pend=%h want 0/00", i, reg_write_en, pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_different_dests();
        test_same_dest_ordering();
        test_same_edge_same_dest();
        test_dest_zero();
        test_hazard();
        test_reset_mid_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
